// File: rtl/alu_cmd_issuer_pkg.sv
// Shared command types for the ALU command issuer: unit select, per-unit op codes and the
// packed command word stored in the issue FIFO.
package alu_cmd_issuer_pkg;

  localparam int CMD_DATA_W = 8;
  localparam int CMD_TAG_W  = 4;

  typedef enum bit {UNIT_A, UNIT_B} alu_unit_e;

  typedef enum bit [1:0] {AND_A, NAND_A, OR_A, XOR_A} op_a_e;
  typedef enum bit [1:0] {XNOR_B, AND_B, NOR_B, OR_B} op_b_e;

  typedef struct packed {
    alu_unit_e             unit;
    bit [1:0]              op;
    bit [CMD_DATA_W-1:0]   a;
    bit [CMD_DATA_W-1:0]   b;
    bit [CMD_TAG_W-1:0]    tag;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of alu_cmd_t; pushes are ignored when full, pops when empty.
// full/empty are decoded from the registered count, so they never depend on this cycle's pop.
module alu_cmd_fifo
  import alu_cmd_issuer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  alu_cmd_t                 wdata,
  input  logic                     pop,
  output alu_cmd_t                 rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  alu_cmd_t        mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Buffers tagged ALU commands, issues one per cycle to the alu, and returns alu_c with its tag
// after ALU_LAT cycles through a tag/valid shift pipeline.
module alu_cmd_issuer
  import alu_cmd_issuer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 8,
  parameter int TAG_W   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_unit,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic              alu_en,
  output logic              alu_a_en,
  output logic              alu_b_en,
  output logic [1:0]        alu_a_op,
  output logic [1:0]        alu_b_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_c,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              busy
);

  alu_cmd_t                 wcmd;
  alu_cmd_t                 head;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     issue;
  logic                     head_is_a;
  logic                     head_is_b;

  logic [ALU_LAT:0]         stg_vld;
  logic [TAG_W-1:0]         stg_tag [ALU_LAT+1];

  assign wcmd = '{unit: alu_unit_e'(cmd_unit), op: cmd_op, a: cmd_a, b: cmd_b, tag: cmd_tag};

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .wdata (wcmd),
    .pop   (issue),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign cmd_ready = !full;
  assign issue     = !empty;
  assign head_is_a = issue && (head.unit == UNIT_A);
  assign head_is_b = issue && (head.unit == UNIT_B);

  // Issue register and pipeline valids; stage 0 loads on the same edge as alu_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_en    <= 1'b0;
      alu_a_en  <= 1'b0;
      alu_b_en  <= 1'b0;
      alu_a_op  <= '0;
      alu_b_op  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      stg_vld   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
    end else begin
      alu_en    <= issue;
      alu_a_en  <= head_is_a;
      alu_b_en  <= head_is_b;
      alu_a_op  <= head_is_a ? head.op : 2'b00;
      alu_b_op  <= head_is_b ? head.op : 2'b00;
      alu_a     <= issue ? head.a : '0;
      alu_b     <= issue ? head.b : '0;
      stg_vld   <= {stg_vld[ALU_LAT-1:0], issue};
      rsp_valid <= stg_vld[ALU_LAT];
      if (stg_vld[ALU_LAT]) begin
        rsp_data <= alu_c;
        rsp_tag  <= stg_tag[ALU_LAT];
      end
    end
  end

  always_ff @(posedge clk) begin
    stg_tag[0] <= head.tag;
    for (int i = 1; i <= ALU_LAT; i++) begin
      stg_tag[i] <= stg_tag[i-1];
    end
  end

  assign busy = (count != '0) || (|stg_vld) || rsp_valid;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: registered alu model, expected-response queue filled on
// each accepted command and drained by a negedge monitor whenever rsp_valid is seen.
module tb_alu_cmd_issuer;
  import alu_cmd_issuer_pkg::*;

  localparam int DEPTH = 4, DATA_W = 8, TAG_W = 4, ALU_LAT = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_unit = 1'b0;
  logic [1:0]        cmd_op = '0;
  logic [DATA_W-1:0] cmd_a = '0;
  logic [DATA_W-1:0] cmd_b = '0;
  logic [TAG_W-1:0]  cmd_tag = '0;
  logic              alu_en, alu_a_en, alu_b_en;
  logic [1:0]        alu_a_op, alu_b_op;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic [DATA_W-1:0] alu_c = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [TAG_W-1:0]  rsp_tag;
  logic              busy;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_unit(cmd_unit),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag), .alu_en(alu_en),
    .alu_a_en(alu_a_en), .alu_b_en(alu_b_en), .alu_a_op(alu_a_op), .alu_b_op(alu_b_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .busy(busy)
  );

  // One-cycle alu: result valid the cycle after alu_en.
  always @(posedge clk) begin
    if (alu_en) begin
      if (alu_a_en) begin
        case (alu_a_op)
          2'd0:    alu_c <= alu_a & alu_b;
          2'd1:    alu_c <= ~(alu_a & alu_b);
          2'd2:    alu_c <= alu_a | alu_b;
          default: alu_c <= alu_a ^ alu_b;
        endcase
      end else begin
        case (alu_b_op)
          2'd0:    alu_c <= ~(alu_a ^ alu_b);
          2'd1:    alu_c <= alu_a & alu_b;
          2'd2:    alu_c <= ~(alu_a | alu_b);
          default: alu_c <= alu_a | alu_b;
        endcase
      end
    end
  end

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  exp_t e;
  bit   mon_en = 1'b0;
  int   mcnt = 0;
  logic exp_en = 1'b0;
  int   hs_cnt = 0;
  int   rsp_cnt = 0;

  // Unit A results for A=F0, B=3C: AND, NAND, OR, XOR.
  logic [7:0] a_res [4] = '{8'h30, 8'hCF, 8'hFC, 8'hCC};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop, occupancy model for cmd_ready and alu_en.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_valid) begin
        rsp_cnt++;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got tag %0h data %0h expected no response", rsp_tag, rsp_data);
        end else begin
          e = sbq.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
        end
      end
      chk("alu_en_model", 32'(alu_en), 32'(exp_en));
      chk("cmd_ready_model", 32'(cmd_ready), 32'(mcnt != DEPTH));
      if (cmd_valid && cmd_ready && !rst) hs_cnt++;
      exp_en = !rst && (mcnt != 0);
      if (rst) begin
        sbq.delete();
        mcnt = 0;
      end else begin
        mcnt = mcnt + int'(cmd_valid && cmd_ready) - int'(mcnt != 0);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after the handshake, cmd_valid left high.
  task automatic send(input bit unit, input logic [1:0] op, input logic [3:0] tag,
                      input logic [7:0] exp);
    bit r = 1'b0;
    int n = 0;
    cmd_valid = 1'b1;
    cmd_unit  = unit;
    cmd_op    = op;
    cmd_a     = 8'hF0;
    cmd_b     = 8'h3C;
    cmd_tag   = tag;
    do begin
      @(negedge clk);
      r = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 50);
    if (!r) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no handshake for tag %0h expected one within 50 cycles", tag);
    end else begin
      sbq.push_back('{exp, tag});
    end
  endtask

  task automatic wait_rsp(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: got no rsp_valid expected one within 30 cycles", name);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 32'(sbq.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({pfx, "_alu_en"},    32'(alu_en),    32'd0);
    chk({pfx, "_alu_a_en"},  32'(alu_a_en),  32'd0);
    chk({pfx, "_alu_b_en"},  32'(alu_b_en),  32'd0);
    chk({pfx, "_alu_a_op"},  32'(alu_a_op),  32'd0);
    chk({pfx, "_alu_b_op"},  32'(alu_b_op),  32'd0);
    chk({pfx, "_alu_a"},     32'(alu_a),     32'd0);
    chk({pfx, "_alu_b"},     32'(alu_b),     32'd0);
    chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({pfx, "_rsp_data"},  32'(rsp_data),  32'd0);
    chk({pfx, "_rsp_tag"},   32'(rsp_tag),   32'd0);
    chk({pfx, "_busy"},      32'(busy),      32'd0);
  endtask

  initial begin
    bit ok;
    int hs0, rsp0;

    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    check_reset_vals("reset");

    // 1: single unit-A AND, tag 3
    send(UNIT_A, 2'(AND_A), 4'd3, 8'h30);
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("t1_alu_en",   32'(alu_en),   32'd1);
    chk("t1_alu_a_en", 32'(alu_a_en), 32'd1);
    chk("t1_alu_b_en", 32'(alu_b_en), 32'd0);
    chk("t1_alu_a_op", 32'(alu_a_op), 32'(AND_A));
    chk("t1_alu_b_op", 32'(alu_b_op), 32'd0);
    chk("t1_alu_a",    32'(alu_a),    32'hF0);
    chk("t1_alu_b",    32'(alu_b),    32'h3C);
    @(posedge clk); #1;
    chk("t1_rsp_early", 32'(rsp_valid), 32'd0);
    chk("t1_alu_en_off", 32'(alu_en), 32'd0);
    @(posedge clk); #1;
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_data",  32'(rsp_data),  32'h30);
    drain("t1_drain");

    // 2: four back-to-back unit-B commands
    send(UNIT_B, 2'(XNOR_B), 4'd0, 8'h33);
    send(UNIT_B, 2'(AND_B),  4'd1, 8'h30);
    send(UNIT_B, 2'(NOR_B),  4'd2, 8'h03);
    send(UNIT_B, 2'(OR_B),   4'd3, 8'hFC);
    cmd_valid = 1'b0;
    wait_rsp("t2_wait", ok);
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        chk("t2_rsp_consecutive", 32'(rsp_valid), 32'd1);
        @(posedge clk); #1;
      end
      chk("t2_rsp_end", 32'(rsp_valid), 32'd0);
    end
    drain("t2_drain");

    // 3: cmd_valid held six cycles while the FIFO drains
    hs0  = hs_cnt;
    rsp0 = rsp_cnt;
    for (int i = 0; i < 6; i++) send(UNIT_A, 2'(i % 4), 4'(4 + i), a_res[i % 4]);
    cmd_valid = 1'b0;
    drain("t3_drain");
    chk("t3_handshakes", 32'(hs_cnt - hs0), 32'd6);
    chk("t3_responses",  32'(rsp_cnt - rsp0), 32'd6);

    // 4: pointer wrap, 3*DEPTH+1 commands
    rsp0 = rsp_cnt;
    for (int i = 0; i < 3 * DEPTH + 1; i++) send(UNIT_A, 2'(i % 4), 4'(8 + i), a_res[i % 4]);
    cmd_valid = 1'b0;
    drain("t4_drain");
    chk("t4_responses", 32'(rsp_cnt - rsp0), 32'(3 * DEPTH + 1));

    // 5: reset with commands queued and in flight
    for (int i = 0; i < 4; i++) send(UNIT_A, 2'(i % 4), 4'(i), a_res[i % 4]);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_vals("t5");
    for (int i = 0; i < 8; i++) begin
      chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    rsp0 = rsp_cnt;
    send(UNIT_A, 2'(XOR_A), 4'd9, 8'hCC);
    cmd_valid = 1'b0;
    drain("t5_drain");
    chk("t5_responses", 32'(rsp_cnt - rsp0), 32'd1);

    // 6: idle outputs and busy fall
    chk("t6_idle_alu_en",   32'(alu_en),   32'd0);
    chk("t6_idle_alu_a_en", 32'(alu_a_en), 32'd0);
    chk("t6_idle_alu_b_en", 32'(alu_b_en), 32'd0);
    chk("t6_idle_busy",     32'(busy),     32'd0);
    send(UNIT_B, 2'(OR_B), 4'd7, 8'hFC);
    cmd_valid = 1'b0;
    chk("t6_busy_queued", 32'(busy), 32'd1);
    wait_rsp("t6_wait", ok);
    if (ok) begin
      chk("t6_busy_at_rsp", 32'(busy), 32'd1);
      @(posedge clk); #1;
      chk("t6_busy_after", 32'(busy), 32'd0);
      chk("t6_rsp_after",  32'(rsp_valid), 32'd0);
    end
    drain("t6_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
